// File: rtl/fix_checksum_trailer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fix_pkg: FIX trailer constants and trailer state type.  Rev 1.0    |
// +--------------------------------------------------------------------+
package fix_pkg;

  localparam logic [7:0] FIX_SOH    = 8'h01;
  localparam logic [7:0] FIX_EQ     = 8'h3D;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ONE  = 8'h31;

  typedef enum logic [3:0] {
    IDLE,
    BODY,
    T_1,
    T_0,
    T_EQ,
    T_D2,
    T_D1,
    T_D0,
    T_SOH
  } trailer_state_t;

endpackage
`default_nettype wire

// File: rtl/fix_checksum_trailer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fix_checksum_trailer_if: byte stream in/out bundle.  Rev 1.0       |
// +--------------------------------------------------------------------+
interface fix_checksum_trailer_if;

  logic [7:0] data_i;
  logic       data_valid_i;
  logic       start_checksum_i;
  logic       end_i;
  logic       in_ready_o;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       msg_end_o;
`ifdef FIX_CKSUM_STATUS_EN
  logic [7:0] cksum_o;
  logic       cksum_valid_o;

  modport master (
    output data_i, data_valid_i, start_checksum_i, end_i,
    input  in_ready_o, data_o, data_valid_o, msg_end_o, cksum_o, cksum_valid_o
  );
  modport slave (
    input  data_i, data_valid_i, start_checksum_i, end_i,
    output in_ready_o, data_o, data_valid_o, msg_end_o, cksum_o, cksum_valid_o
  );
`else
  modport master (
    output data_i, data_valid_i, start_checksum_i, end_i,
    input  in_ready_o, data_o, data_valid_o, msg_end_o
  );
  modport slave (
    input  data_i, data_valid_i, start_checksum_i, end_i,
    output in_ready_o, data_o, data_valid_o, msg_end_o
  );
`endif

endinterface
`default_nettype wire

// File: rtl/fix_checksum_trailer_bin2ascii3.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fix_bin2ascii3: 8-bit value to three ASCII decimal digits. Rev 1.0 |
// +--------------------------------------------------------------------+
module fix_bin2ascii3
  import fix_pkg::*;
(
  input  logic [7:0] bin,
  output logic [7:0] hundreds,
  output logic [7:0] tens,
  output logic [7:0] units
);

  logic [7:0] h_val;
  logic [7:0] t_val;
  logic [7:0] u_val;

  assign h_val = bin / 8'd100;
  assign t_val = (bin / 8'd10) % 8'd10;
  assign u_val = bin % 8'd10;

  assign hundreds = ASCII_ZERO + h_val;
  assign tens     = ASCII_ZERO + t_val;
  assign units    = ASCII_ZERO + u_val;

endmodule
`default_nettype wire

// File: rtl/fix_checksum_trailer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fix_checksum_trailer: body pass-through + "10=nnn<SOH>" trailer.   |
// | Option macro FIX_CKSUM_STATUS_EN adds cksum_o/cksum_valid_o. R1.0  |
// +--------------------------------------------------------------------+
module fix_checksum_trailer
  import fix_pkg::*;
#(
  parameter logic [7:0] SOH_CHAR = FIX_SOH
) (
  input  logic                   clk,
  input  logic                   rst,
  fix_checksum_trailer_if.slave  bus
);

  trailer_state_t state;
  logic [7:0]     sum;
  logic [7:0]     sum_next;
  logic           accept;
  logic [7:0]     dig_h;
  logic [7:0]     dig_t;
  logic [7:0]     dig_u;

  assign bus.in_ready_o = (state == IDLE) || (state == BODY);
  assign accept         = bus.data_valid_i && bus.in_ready_o;
  assign sum_next       = sum + bus.data_i;

  // Digits come straight off the sum register, which is frozen once in T_1.
  fix_bin2ascii3 u_bin2ascii3 (
    .bin      (sum),
    .hundreds (dig_h),
    .tens     (dig_t),
    .units    (dig_u)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      sum              <= 8'h00;
      bus.data_o       <= 8'h00;
      bus.data_valid_o <= 1'b0;
      bus.msg_end_o    <= 1'b0;
`ifdef FIX_CKSUM_STATUS_EN
      bus.cksum_o       <= 8'h00;
      bus.cksum_valid_o <= 1'b0;
`endif
    end else begin
      bus.data_valid_o <= 1'b0;
      bus.msg_end_o    <= 1'b0;
`ifdef FIX_CKSUM_STATUS_EN
      bus.cksum_valid_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            bus.data_o       <= bus.data_i;
            bus.data_valid_o <= 1'b1;
            if (bus.start_checksum_i) begin
              sum   <= bus.data_i;
              state <= bus.end_i ? T_1 : BODY;
`ifdef FIX_CKSUM_STATUS_EN
              if (bus.end_i) begin
                bus.cksum_o       <= bus.data_i;
                bus.cksum_valid_o <= 1'b1;
              end
`endif
            end
          end
        end
        BODY: begin
          if (accept) begin
            bus.data_o       <= bus.data_i;
            bus.data_valid_o <= 1'b1;
            sum              <= sum_next;
            if (bus.end_i) begin
              state <= T_1;
`ifdef FIX_CKSUM_STATUS_EN
              bus.cksum_o       <= sum_next;
              bus.cksum_valid_o <= 1'b1;
`endif
            end
          end
        end
        T_1: begin
          bus.data_o       <= ASCII_ONE;
          bus.data_valid_o <= 1'b1;
          state            <= T_0;
        end
        T_0: begin
          bus.data_o       <= ASCII_ZERO;
          bus.data_valid_o <= 1'b1;
          state            <= T_EQ;
        end
        T_EQ: begin
          bus.data_o       <= FIX_EQ;
          bus.data_valid_o <= 1'b1;
          state            <= T_D2;
        end
        T_D2: begin
          bus.data_o       <= dig_h;
          bus.data_valid_o <= 1'b1;
          state            <= T_D1;
        end
        T_D1: begin
          bus.data_o       <= dig_t;
          bus.data_valid_o <= 1'b1;
          state            <= T_D0;
        end
        T_D0: begin
          bus.data_o       <= dig_u;
          bus.data_valid_o <= 1'b1;
          state            <= T_SOH;
        end
        T_SOH: begin
          bus.data_o       <= SOH_CHAR;
          bus.data_valid_o <= 1'b1;
          bus.msg_end_o    <= 1'b1;
          sum              <= 8'h00;
          state            <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/fix_checksum_trailer.md
FIX_CHECKSUM_TRAILER -- requirements
Module: fix_checksum_trailer

Interface
REQ-001 Parameter: SOH_CHAR, default 8'h01, field delimiter byte appended after the checksum digits.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 data_i  input  8  body byte from the message-create stage.
REQ-005 data_valid_i  input  1  data_i valid this cycle.
REQ-006 start_checksum_i  input  1  qualifies data_i as the first byte of the checksummed body.
REQ-007 end_i  input  1  qualifies data_i as the last body byte; triggers trailer.
REQ-008 in_ready_o  output  1  high when a valid input byte is accepted.
REQ-009 data_o  output  8  outgoing byte stream (body pass-through, then trailer).
REQ-010 data_valid_o  output  1  data_o valid.
REQ-011 msg_end_o  output  1  one-cycle pulse with the final SOH_CHAR of the trailer.

Function
REQ-012 An input byte is accepted when data_valid_i && in_ready_o; bytes presented while in_ready_o is low are dropped and do not affect the sum.
REQ-013 in_ready_o is high only in states IDLE and BODY.
REQ-014 Latency: a byte accepted in cycle N appears on data_o with data_valid_o=1 in cycle N+1; data_valid_o=0 in cycles where no byte was accepted and no trailer byte is due.
REQ-015 States: IDLE, BODY, T_1, T_0, T_EQ, T_D2, T_D1, T_D0, T_SOH.
REQ-016 IDLE: accepted byte without start_checksum_i passes through unsummed, state stays IDLE.
REQ-017 IDLE: accepted byte with start_checksum_i loads sum with data_i; next state BODY, or T_1 if end_i is also set.
REQ-018 BODY: each accepted byte adds data_i to sum modulo 256 (8-bit wrap); start_checksum_i is ignored; accepted byte with end_i moves to T_1.
REQ-019 end_i accepted in IDLE without start_checksum_i is ignored (plain pass-through).
REQ-020 Trailer: end byte accepted in cycle N -> data_o = 8'h31, 8'h30, 8'h3D, hundreds, tens, units digit, SOH_CHAR in cycles N+2..N+8, data_valid_o=1 each cycle.
REQ-021 Digits are ASCII 8'h30 + decimal digit of the final 8-bit sum (0..255), always three digits with leading zeros.
REQ-022 msg_end_o=1 only in cycle N+8; state returns to IDLE at N+8 and in_ready_o is high again in N+8.
REQ-023 in_ready_o is low in cycles N+1..N+7 (exactly 7 cycles).
REQ-024 The sum register is cleared on entry to IDLE after the trailer.

Reset
REQ-025 On rst: state=IDLE, sum=0, data_o=8'h00, data_valid_o=0, msg_end_o=0; in_ready_o=1 the cycle after rst deasserts.
REQ-026 rst asserted mid-body or mid-trailer aborts immediately; no further trailer bytes are emitted.

Configuration
REQ-027 Macro FIX_CKSUM_STATUS_EN defined: adds outputs cksum_o[7:0] (final binary sum) and cksum_valid_o (1-cycle pulse in cycle N+1 of REQ-020); both 0 in reset.
REQ-028 Macro FIX_CKSUM_STATUS_EN undefined: those ports do not exist; all other behaviour is identical.

Structure
REQ-029 Shared package fix_pkg holds FIX_SOH (8'h01), FIX_EQ (8'h3D), ASCII_ZERO (8'h30), and the trailer state enum type.
REQ-030 Sub-module fix_bin2ascii3 converts the 8-bit sum into three ASCII digit bytes combinationally.

Verification
REQ-031 Body 38 3D 46 49 58 (start on first, end on last) -> pass-through then 31 30 3D 30 39 32 01 ("10=092\x01"), msg_end_o on 01.
REQ-032 Body FF FF FF -> sum wraps to 253 -> trailer digits 32 35 33.
REQ-033 Single byte 00 with start_checksum_i and end_i together -> trailer digits 30 30 30, trailer starts 2 cycles later.
REQ-034 data_valid_i held high through the trailer -> those 7 bytes dropped, in_ready_o low 7 cycles, sum of next message unaffected.
REQ-035 rst asserted at trailer digit T_D1 -> data_valid_o=0 next cycle, no SOH, next message checksum correct.
REQ-036 Gaps (data_valid_i low) between body bytes -> data_valid_o low for matching cycles, checksum unchanged.
